// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory / character-stream arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W        = 12;
    localparam int DATA_W        = 32;
    localparam int CHAR_W        = 8;
    localparam int BASE_ADDR_DEF = 1500;
    localparam int BUF_LEN_DEF   = 108;
    localparam int CNT_W         = $clog2(BUF_LEN_DEF + 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_CHAR
    } grant_e;
endpackage

// File: rtl/dmem_char_arbiter_fifo.sv
// Small synchronous character FIFO with flush; head is visible whenever non-empty.
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/dmem_char_arbiter.sv
// Shares the single RAM port between the processor (priority) and buffered characters,
// with a starvation guard that steals one processor cycle for a queued character.
module dmem_char_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BASE_ADDR    = BASE_ADDR_DEF,
    parameter int BUF_LEN      = BUF_LEN_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_mem_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [CHAR_W-1:0] char_data,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              buf_clear,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              cpu_stall,
    output logic [CNT_W-1:0]  char_count,
    output logic              buf_full
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    if (BASE_ADDR + BUF_LEN - 1 > (1 << ADDR_W) - 1) begin : g_bad_range
        $error("character buffer exceeds the 12-bit RAM address space");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two");
    end

    logic              fifo_full, fifo_empty;
    logic [CHAR_W-1:0] fifo_head;
    logic              push, pop, starved;
    grant_e            grant;
    logic [CNT_W-1:0]  char_count_q, char_count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;

    assign char_ready = !fifo_full && !reset;
    assign push       = char_valid && char_ready && !buf_clear;
    assign buf_full   = (char_count_q == CNT_W'(BUF_LEN));
    assign char_count = char_count_q;
    assign cpu_stall  = stall_q;

    char_fifo #(.WIDTH(CHAR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .flush_i (buf_clear),
        .push_i  (push),
        .data_i  (char_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        grant = GNT_NONE;
        if (reset)                                        grant = GNT_NONE;
        else if (cpu_mem_req && !stall_q)                 grant = GNT_CPU;
        else if (!fifo_empty && !buf_full && !buf_clear)  grant = GNT_CHAR;
    end

    // Without a grant the processor signals still pass through, write gated off by a stall.
    always_comb begin
        ram_wren = cpu_wren && !stall_q && !reset;
        ram_addr = cpu_addr;
        ram_data = cpu_data;
        if (grant == GNT_CHAR) begin
            ram_wren = 1'b1;
            ram_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(char_count_q);
            ram_data = {{(DATA_W-CHAR_W){1'b0}}, fifo_head};
        end
    end

    assign pop     = (grant == GNT_CHAR);
    assign starved = !fifo_empty && !buf_full && (grant != GNT_CHAR);

    always_comb begin
        char_count_d = char_count_q;
        starve_d     = starve_q;
        stall_d      = 1'b0;
        if (buf_clear) begin
            char_count_d = '0;
            starve_d     = '0;
        end else begin
            if (pop) char_count_d = char_count_q + CNT_W'(1);
            if (!starved) begin
                starve_d = '0;
            end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            char_count_q <= '0;
            starve_q     <= '0;
            stall_q      <= 1'b0;
        end else begin
            char_count_q <= char_count_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_dmem_char_arbiter.sv
// Directed vector bench for dmem_char_arbiter: table of hand-computed cycles plus reset sequences.
module tb_dmem_char_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_mem_req, cpu_wren;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_data;
    logic [7:0]  char_data;
    logic        char_valid, char_ready, buf_clear;
    logic        ram_wren;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic        cpu_stall;
    logic [6:0]  char_count;
    logic        buf_full;

    int n_vec = 0;
    int n_err = 0;

    dmem_char_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_mem_req (cpu_mem_req),
        .cpu_wren    (cpu_wren),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .char_data   (char_data),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .buf_clear   (buf_clear),
        .ram_wren    (ram_wren),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .cpu_stall   (cpu_stall),
        .char_count  (char_count),
        .buf_full    (buf_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        req, wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [7:0]  cd;
        logic        cv, clr;
        logic        e_wren;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic        e_stall, e_ready;
        logic [6:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int req, input int wr, input int addr, input logic [31:0] data,
                       input int cd, input int cv, input int clr,
                       input int ew, input int ea, input logic [31:0] ed,
                       input int es, input int er, input int ec, input int ef);
        vec_t v;
        v.req = 1'(req); v.wr = 1'(wr); v.addr = 12'(addr); v.data = data;
        v.cd = 8'(cd); v.cv = 1'(cv); v.clr = 1'(clr);
        v.e_wren = 1'(ew); v.e_addr = 12'(ea); v.e_data = ed;
        v.e_stall = 1'(es); v.e_ready = 1'(er); v.e_cnt = 7'(ec); v.e_full = 1'(ef);
        vq.push_back(v);
    endtask

    task automatic drive(input int req, input int wr, input int addr, input logic [31:0] data,
                         input int cd, input int cv, input int clr);
        cpu_mem_req = 1'(req); cpu_wren = 1'(wr); cpu_addr = 12'(addr); cpu_data = data;
        char_data = 8'(cd); char_valid = 1'(cv); buf_clear = 1'(clr);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_row(input int cnt, input int full);
        add(0,0,0,32'h0, 0,0,0, 0,0,32'h0, 0,1,cnt,full);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;

        // ---- vector table ----
        idle_row(0, 0);
        add(0,0,7,32'h0, 'h41,1,0, 0,7,32'h0, 0,1,0,0);
        add(0,0,0,32'h0, 0,0,0, 1,1500,32'h41, 0,1,0,0);
        idle_row(1, 0);
        // processor priority, then char written at 1501
        add(1,1,20,32'd5, 'h42,1,0, 1,20,32'd5, 0,1,1,0);
        add(1,1,20,32'd5, 0,0,0,    1,20,32'd5, 0,1,1,0);
        add(0,0,0,32'h0, 0,0,0, 1,1501,32'h42, 0,1,1,0);
        add(1,0,100,32'hdeadbeef, 0,0,0, 0,100,32'hdeadbeef, 0,1,2,0);
        // starvation: stall lands in the 9th cycle the char waits
        add(1,1,30,32'd9, 'h43,1,0, 1,30,32'd9, 0,1,2,0);
        for (int i = 1; i <= 8; i++) add(1,1,30,32'd9, 0,0,0, 1,30,32'd9, 0,1,2,0);
        add(1,1,30,32'd9, 0,0,0, 1,1502,32'h43, 1,1,2,0);
        add(1,1,30,32'd9, 0,0,0, 1,30,32'd9,    0,1,3,0);
        // backpressure: 4 accepted, 5th refused
        for (int i = 0; i < 4; i++) add(1,1,31,32'h0, 'h50+i,1,0, 1,31,32'h0, 0,1,3,0);
        add(1,1,31,32'h0, 'h54,1,0, 1,31,32'h0, 0,0,3,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,32'h0, 0,0,0, 1,1503+i,32'('h50+i), 0,(i==0)?0:1,3+i,0);
        idle_row(7, 0);
        // fill to capacity, push and pop together each cycle
        for (int k = 0; k <= 100; k++) begin
            c = 8'h60 + 8'(k);
            if (k == 0) add(0,0,0,32'h0, c,1,0, 0,0,32'h0, 0,1,7,0);
            else        add(0,0,0,32'h0, c,1,0, 1,1507+k-1,32'(8'(c-8'd1)), 0,1,7+k-1,0);
        end
        add(0,0,0,32'h0, 0,0,0, 1,1607,32'hc4, 0,1,107,0);
        add(0,0,0,32'h0, 0,0,0, 0,0,32'h0,     0,1,108,1);
        // full: no writes, FIFO fills, no stall
        for (int i = 0; i < 4; i++) add(0,0,0,32'h0, 'h80+i,1,0, 0,0,32'h0, 0,1,108,1);
        add(0,0,0,32'h0, 'h84,1,0, 0,0,32'h0, 0,0,108,1);
        for (int i = 0; i < 10; i++) add(1,1,40,32'd7, 0,0,0, 1,40,32'd7, 0,0,108,1);
        // clear
        add(0,0,0,32'h0, 'h70,1,1, 0,0,32'h0, 0,0,108,1);
        add(0,0,0,32'h0, 'h71,1,0, 0,0,32'h0, 0,1,0,0);
        add(0,0,3,32'h0, 'h72,1,1, 0,3,32'h0, 0,1,0,0);
        idle_row(0, 0);
        add(0,0,0,32'h0, 'h73,1,0, 0,0,32'h0, 0,1,0,0);
        add(0,0,0,32'h0, 0,0,0, 1,1500,32'h73, 0,1,0,0);
        idle_row(1, 0);
        // clear on the last starved cycle cancels the stall
        add(1,1,50,32'd3, 'h74,1,0, 1,50,32'd3, 0,1,1,0);
        for (int i = 1; i <= 8; i++) add(1,1,50,32'd3, 0,0,(i==8)?1:0, 1,50,32'd3, 0,1,1,0);
        add(1,1,50,32'd3, 0,0,0, 1,50,32'd3, 0,1,0,0);
        idle_row(0, 0);

        // ---- reset ----
        reset = 1'b1;
        drive(1,1,5,32'h1, 'h99,1,0);
        @(negedge clock); #1;
        n_vec++;
        chk("reset char_ready", 32'(char_ready), 32'h0);
        chk("reset ram_wren", 32'(ram_wren), 32'h0);
        chk("reset cpu_stall", 32'(cpu_stall), 32'h0);
        @(negedge clock); #1;
        n_vec++;
        chk("reset char_count", 32'(char_count), 32'h0);
        chk("reset buf_full", 32'(buf_full), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(0,0,0,32'h0, 0,0,0);

        // ---- apply table ----
        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i].req, vq[i].wr, vq[i].addr, vq[i].data, vq[i].cd, vq[i].cv, vq[i].clr);
            #1;
            n_vec++;
            chk($sformatf("v%0d ram_wren", i),   32'(ram_wren),   32'(vq[i].e_wren));
            if (vq[i].e_wren || !vq[i].req)
                chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vq[i].e_addr));
            chk($sformatf("v%0d ram_data", i),   ram_data,        vq[i].e_data);
            chk($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),  32'(vq[i].e_stall));
            chk($sformatf("v%0d char_ready", i), 32'(char_ready), 32'(vq[i].e_ready));
            chk($sformatf("v%0d char_count", i), 32'(char_count), 32'(vq[i].e_cnt));
            chk($sformatf("v%0d buf_full", i),   32'(buf_full),   32'(vq[i].e_full));
        end

        // ---- reset mid-operation discards queued char ----
        @(negedge clock); drive(0,0,0,32'h0, 'h75,1,0);
        @(negedge clock); drive(0,0,0,32'h0, 0,0,0); #1;
        n_vec++;
        chk("midrst pre ram_wren", 32'(ram_wren), 32'h1);
        chk("midrst pre ram_addr", 32'(ram_addr), 32'd1500);
        @(negedge clock); drive(1,1,60,32'h1, 'h76,1,0);
        @(negedge clock); drive(1,1,60,32'h1, 0,0,0);
        @(negedge clock);
        @(negedge clock); reset = 1'b1; #1;
        n_vec++;
        chk("midrst ram_wren", 32'(ram_wren), 32'h0);
        chk("midrst char_ready", 32'(char_ready), 32'h0);
        @(negedge clock); reset = 1'b0; drive(0,0,0,32'h0, 0,0,0); #1;
        n_vec++;
        chk("midrst post ram_wren", 32'(ram_wren), 32'h0);
        chk("midrst post char_count", 32'(char_count), 32'h0);
        chk("midrst post cpu_stall", 32'(cpu_stall), 32'h0);
        @(negedge clock); drive(0,0,0,32'h0, 'h77,1,0);
        @(negedge clock); drive(0,0,0,32'h0, 0,0,0); #1;
        n_vec++;
        chk("midrst next ram_wren", 32'(ram_wren), 32'h1);
        chk("midrst next ram_addr", 32'(ram_addr), 32'd1500);
        chk("midrst next ram_data", ram_data, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
